// File: rtl/alu.sv
// 8-bit four-unit ALU (arithmetic, shifter, comparator, logic) with a registered 16-bit result.
// Optional status flags are built only when ALU_FLAGS_EN is defined.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  m,
    input  logic [1:0]  s,
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
`ifdef ALU_FLAGS_EN
    output logic [3:0]  flags,
`endif
    output logic [15:0] Z
);

    logic [8:0]  sum;
    logic [15:0] diff;
    logic [15:0] prod;
    logic [7:0]  shift_r;
    logic [7:0]  logic_r;
    logic [15:0] z_next;

    assign sum  = {1'b0, X} + {1'b0, Y};
    // Zero-extending both operands to 16 bits makes a negative difference sign-extend naturally.
    assign diff = {8'h00, X} - {8'h00, Y};
    assign prod = {8'h00, X} * {8'h00, Y};

    always_comb begin
        shift_r = 8'h00;
        case (m)
            2'b00:   shift_r = {X[6:0], 1'b0};
            2'b01:   shift_r = {1'b1, X[7:1]};
            2'b10:   shift_r = {X[6:0], X[7]};
            default: shift_r = {X[0], X[7:1]};
        endcase
    end

    always_comb begin
        logic_r = 8'h00;
        case (m)
            2'b00:   logic_r = X & Y;
            2'b01:   logic_r = X | Y;
            2'b10:   logic_r = ~X;
            default: logic_r = X ^ Y;
        endcase
    end

    always_comb begin
        z_next = 16'h0000;
        case (s)
            2'b00: begin
                case (m)
                    2'b00:   z_next = {7'd0, sum};
                    2'b01:   z_next = diff;
                    2'b10:   z_next = prod;
                    default: z_next = 16'h0000;
                endcase
            end
            2'b01:   z_next = {8'h00, shift_r};
            2'b10:   z_next = {13'd0, (X < Y), (X == Y), (X > Y)};
            default: z_next = {8'h00, logic_r};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Z <= 16'h0000;
        end else begin
            Z <= z_next;
        end
    end

`ifdef ALU_FLAGS_EN
    logic       shift_out;
    logic       carry_next;
    logic [3:0] flags_next;

    // Left moves drop/rotate bit 7, right moves drop/rotate bit 0.
    assign shift_out = m[0] ? X[0] : X[7];

    always_comb begin
        carry_next = 1'b0;
        if (s == 2'b00) begin
            case (m)
                2'b00:   carry_next = sum[8];
                2'b01:   carry_next = (X < Y);
                default: carry_next = 1'b0;
            endcase
        end
    end

    always_comb begin
        flags_next    = 4'h0;
        flags_next[0] = (z_next == 16'h0000);
        flags_next[1] = z_next[15];
        flags_next[2] = carry_next;
        flags_next[3] = (s == 2'b01) ? shift_out : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 4'h0;
        end else begin
            flags <= flags_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [1:0]  m;
    logic [1:0]  s;
    logic [7:0]  X;
    logic [7:0]  Y;
    logic [15:0] Z;
`ifdef ALU_FLAGS_EN
    logic [3:0]  flags;
    logic [3:0]  exp_flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic        check_en = 1'b0;
    logic [15:0] exp_z;

    alu dut (
        .clk   (clk),
        .rst   (rst),
        .m     (m),
        .s     (s),
        .X     (X),
        .Y     (Y),
`ifdef ALU_FLAGS_EN
        .flags (flags),
`endif
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_z(input int su, input int mo, input int a, input int b);
        int r;
        r = 0;
        case (su)
            0: case (mo)
                   0: r = a + b;
                   1: r = (a - b) & 32'hFFFF;
                   2: r = a * b;
                   default: r = 0;
               endcase
            1: case (mo)
                   0: r = (a * 2) % 256;
                   1: r = (a / 2) + 128;
                   2: r = ((a * 2) % 256) + (a / 128);
                   default: r = (a / 2) + ((a % 2) * 128);
               endcase
            2: r = (a > b) ? 1 : ((a == b) ? 2 : 4);
            default: case (mo)
                   0: r = a & b;
                   1: r = a | b;
                   2: r = 255 - a;
                   default: r = a ^ b;
               endcase
        endcase
        return r[15:0];
    endfunction

    function automatic logic [3:0] model_flags(input int su, input int mo, input int a, input int b);
        logic [15:0] z;
        logic [3:0]  f;
        z = model_z(su, mo, a, b);
        f = 4'h0;
        f[0] = (z == 16'h0000);
        f[1] = z[15];
        if (su == 0 && mo == 0) f[2] = (a + b) > 255;
        if (su == 0 && mo == 1) f[2] = a < b;
        if (su == 1) f[3] = (mo % 2 == 1) ? (a % 2 == 1) : (a >= 128);
        return f;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference register: the model's result, captured on the same edges and cleared by the same reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_z <= 16'h0000;
`ifdef ALU_FLAGS_EN
            exp_flags <= 4'h0;
`endif
        end else begin
            exp_z <= model_z(int'(s), int'(m), int'(X), int'(Y));
`ifdef ALU_FLAGS_EN
            exp_flags <= model_flags(int'(s), int'(m), int'(X), int'(Y));
`endif
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle_z", Z, exp_z);
`ifdef ALU_FLAGS_EN
            chk("cycle_flags", {12'd0, flags}, {12'd0, exp_flags});
`endif
        end
    end

    task automatic apply(input logic [1:0] su, input logic [1:0] mo,
                         input logic [7:0] a, input logic [7:0] b, input logic [15:0] req);
        @(negedge clk);
        s = su; m = mo; X = a; Y = b;
        @(posedge clk);
        #1;
        chk("model", model_z(int'(su), int'(mo), int'(a), int'(b)), req);
        chk("z", Z, req);
        $display("s=%b m=%b X=%h Y=%h Z=%h expected=%h", su, mo, a, b, Z, req);
    endtask

`ifdef ALU_FLAGS_EN
    task automatic apply_f(input logic [1:0] su, input logic [1:0] mo,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] req, input logic [3:0] freq);
        apply(su, mo, a, b, req);
        chk("flags", {12'd0, flags}, {12'd0, freq});
        chk("model_flags", {12'd0, model_flags(int'(su), int'(mo), int'(a), int'(b))}, {12'd0, freq});
        $display("flags=%b expected=%b", flags, freq);
    endtask
`endif

    initial begin
        rst = 1'b1;
        s = 2'b00; m = 2'b00; X = 8'h00; Y = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_z", Z, 16'h0000);
        check_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-cycle with a nonzero result held.
        apply(2'b00, 2'b00, 8'd120, 8'd120, 16'h00F0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_z", Z, 16'h0000);
        $display("async reset: Z=%h expected=0000", Z);
        @(negedge clk);
        rst = 1'b0;
        apply(2'b00, 2'b00, 8'd100, 8'd12, 16'h0070);

        apply(2'b00, 2'b00, 8'd255, 8'd255, 16'h01FE);
        apply(2'b00, 2'b01, 8'd50,  8'd25,  16'h0019);
        apply(2'b00, 2'b01, 8'd0,   8'd1,   16'hFFFF);
        apply(2'b00, 2'b10, 8'd255, 8'd1,   16'h00FF);
        apply(2'b00, 2'b10, 8'd3,   8'd5,   16'h000F);
        apply(2'b00, 2'b10, 8'd255, 8'd255, 16'hFE01);
        apply(2'b00, 2'b11, 8'd77,  8'd9,   16'h0000);

        apply(2'b01, 2'b00, 8'hFF, 8'h12, 16'h00FE);
        apply(2'b01, 2'b01, 8'hFF, 8'h34, 16'h00FF);
        apply(2'b01, 2'b01, 8'h02, 8'h00, 16'h0081);
        apply(2'b01, 2'b10, 8'hF0, 8'h56, 16'h00E1);
        apply(2'b01, 2'b11, 8'h0F, 8'h78, 16'h0087);

        apply(2'b10, 2'b00, 8'd255, 8'd0,  16'h0001);
        apply(2'b10, 2'b01, 8'd144, 8'd88, 16'h0001);
        apply(2'b10, 2'b10, 8'd88,  8'd88, 16'h0002);
        apply(2'b10, 2'b11, 8'd0,   8'd1,  16'h0004);

        apply(2'b11, 2'b00, 8'hCC, 8'hAA, 16'h0088);
        apply(2'b11, 2'b01, 8'hCC, 8'hAA, 16'h00EE);
        apply(2'b11, 2'b10, 8'hCC, 8'hAA, 16'h0033);
        apply(2'b11, 2'b11, 8'hCC, 8'hAA, 16'h0066);
        apply(2'b11, 2'b10, 8'hFF, 8'hFF, 16'h0000);
        apply(2'b11, 2'b11, 8'hFF, 8'hFF, 16'h0000);

`ifdef ALU_FLAGS_EN
        apply_f(2'b00, 2'b00, 8'd200, 8'd100, 16'h012C, 4'b0100);
        apply_f(2'b00, 2'b01, 8'd0,   8'd1,   16'hFFFF, 4'b0110);
        apply_f(2'b11, 2'b11, 8'h5A,  8'h5A,  16'h0000, 4'b0001);
        apply_f(2'b01, 2'b00, 8'h80,  8'h00,  16'h0000, 4'b1001);
        apply_f(2'b01, 2'b11, 8'h01,  8'h00,  16'h0080, 4'b1000);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
